// File: rtl/rst_seq_gen_if.sv
// rtl/rst_seq_gen_if.sv - request/acknowledge/status handshake of the reset sequencer
interface rst_seq_gen_if;
  logic req_i;
  logic ack_o;
  logic busy_o;

  modport master (output req_i, input ack_o, input busy_o);
  modport slave  (input req_i, output ack_o, output busy_o);
endinterface

// File: rtl/rst_seq_gen.sv
// rtl/rst_seq_gen.sv - multi-channel reset sequencer: hold all channels, then release them in order
module rst_seq_gen #(
  parameter int NumChannels  = 4,
  parameter int RstClkCycles = 16,
  parameter int GapClkCycles = 4,
  parameter int CntWidth     = $clog2(((RstClkCycles > GapClkCycles) ? RstClkCycles : GapClkCycles) + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  rst_seq_gen_if.slave           bus,
  output logic [NumChannels-1:0] rst_no
);

  localparam int IdxWidth = (NumChannels > 1) ? $clog2(NumChannels) : 1;

  localparam logic [1:0] HOLD    = 2'd0;
  localparam logic [1:0] RELEASE = 2'd1;
  localparam logic [1:0] IDLE    = 2'd2;

  localparam logic [CntWidth-1:0] HoldLast = CntWidth'(RstClkCycles - 1);
  localparam logic [CntWidth-1:0] GapLast  = CntWidth'(GapClkCycles - 1);
  localparam logic [IdxWidth-1:0] IdxLast  = IdxWidth'(NumChannels - 1);

  logic [1:0]          state;
  logic [CntWidth-1:0] cnt;
  logic [IdxWidth-1:0] idx;
  logic                sw;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= HOLD;
      cnt        <= '0;
      idx        <= '0;
      sw         <= 1'b0;
      rst_no     <= '0;
      bus.busy_o <= 1'b1;
      bus.ack_o  <= 1'b0;
    end else begin
      bus.ack_o <= 1'b0;
      case (state)
        HOLD: begin
          if (cnt == HoldLast) begin
            rst_no[0] <= 1'b1;
            cnt       <= '0;
            if (NumChannels == 1) begin
              state      <= IDLE;
              bus.busy_o <= 1'b0;
              bus.ack_o  <= sw;
              sw         <= 1'b0;
            end else begin
              state <= RELEASE;
              idx   <= IdxWidth'(1);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt == GapLast) begin
            // Loop avoids a variable part-select past NumChannels when idx is wider than needed.
            for (int i = 0; i < NumChannels; i++) begin
              if (IdxWidth'(i) == idx) rst_no[i] <= 1'b1;
            end
            cnt <= '0;
            if (idx == IdxLast) begin
              state      <= IDLE;
              bus.busy_o <= 1'b0;
              bus.ack_o  <= sw;
              sw         <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (bus.req_i) begin
            rst_no     <= '0;
            bus.busy_o <= 1'b1;
            sw         <= 1'b1;
            cnt        <= '0;
            idx        <= '0;
            state      <= HOLD;
          end
        end
        default: begin
          state      <= HOLD;
          cnt        <= '0;
          idx        <= '0;
          sw         <= 1'b0;
          rst_no     <= '0;
          bus.busy_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_gen.sv
// tb/tb_rst_seq_gen.sv - checks two sequencer configurations against a timeline model and directed literals
module tb_rst_seq_gen;

  localparam int N0 = 3, R0 = 4, G0 = 2;
  localparam int N1 = 1, R1 = 1, G1 = 1;

  logic       clk = 1'b0;
  logic       rstn0, rstn1;
  logic [2:0] rst_no0;
  logic [0:0] rst_no1;

  rst_seq_gen_if bus0 ();
  rst_seq_gen_if bus1 ();

  rst_seq_gen #(.NumChannels(N0), .RstClkCycles(R0), .GapClkCycles(G0)) dut0 (
    .clk_i(clk), .rst_ni(rstn0), .bus(bus0), .rst_no(rst_no0));
  rst_seq_gen #(.NumChannels(N1), .RstClkCycles(R1), .GapClkCycles(G1)) dut1 (
    .clk_i(clk), .rst_ni(rstn1), .bus(bus1), .rst_no(rst_no1));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic int p_n(input int k); return k ? N1 : N0; endfunction
  function automatic int p_r(input int k); return k ? R1 : R0; endfunction
  function automatic int p_g(input int k); return k ? G1 : G0; endfunction
  function automatic int t_last(input int k); return p_r(k) + (p_n(k) - 1) * p_g(k); endfunction

  // Model: each sequence is described only by the edge number it started on.
  int cyc = 0;
  int start_e[2];
  bit sw_m[2];
  bit ack_m[2];
  bit valid[2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      logic rn, rq;
      int age;
      rn = k ? rstn1 : rstn0;
      rq = k ? bus1.req_i : bus0.req_i;
      if (rn === 1'b0) begin
        start_e[k] = cyc; sw_m[k] = 1'b0; ack_m[k] = 1'b0; valid[k] = 1'b1;
      end else if (valid[k]) begin
        age = cyc - start_e[k];
        if (age > t_last(k) && rq === 1'b1) begin
          start_e[k] = cyc; sw_m[k] = 1'b1; ack_m[k] = 1'b0;
        end else begin
          ack_m[k] = (age == t_last(k)) && sw_m[k];
          if (ack_m[k]) sw_m[k] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (valid[k]) begin
        int age;
        int exp_rst;
        age = cyc - start_e[k];
        exp_rst = 0;
        for (int i = 0; i < p_n(k); i++)
          if (age >= p_r(k) + i * p_g(k)) exp_rst |= (1 << i);
        if (k == 0) begin
          chk("model_rst_no0", int'(rst_no0), exp_rst);
          chk("model_busy0", int'(bus0.busy_o), int'(age < t_last(0)));
          chk("model_ack0", int'(bus0.ack_o), int'(ack_m[0]));
        end else begin
          chk("model_rst_no1", int'(rst_no1), exp_rst);
          chk("model_busy1", int'(bus1.busy_o), int'(age < t_last(1)));
          chk("model_ack1", int'(bus1.ack_o), int'(ack_m[1]));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rstn0 = 1'b0; rstn1 = 1'b0;
    bus0.req_i = 1'b0; bus1.req_i = 1'b0;
    tick(3);
    chk("reset_rst_no0", int'(rst_no0), 0);
    chk("reset_busy0", int'(bus0.busy_o), 1);
    chk("reset_ack0", int'(bus0.ack_o), 0);
    chk("reset_rst_no1", int'(rst_no1), 0);
    rstn0 = 1'b1; rstn1 = 1'b1;
    // Power-on sequence, with a request at E5 that must be ignored.
    tick(1);
    chk("n1_e1_rst", int'(rst_no1), 1);
    chk("n1_e1_busy", int'(bus1.busy_o), 0);
    tick(2);
    chk("po_e3", int'(rst_no0), 3'b000);
    tick(1);
    chk("po_e4", int'(rst_no0), 3'b001);
    bus0.req_i = 1'b1;
    tick(1);
    bus0.req_i = 1'b0;
    chk("po_e5", int'(rst_no0), 3'b001);
    tick(1);
    chk("po_e6", int'(rst_no0), 3'b011);
    tick(1);
    chk("po_e7_busy", int'(bus0.busy_o), 1);
    tick(1);
    chk("po_e8", int'(rst_no0), 3'b111);
    chk("po_e8_busy", int'(bus0.busy_o), 0);
    chk("po_e8_ack", int'(bus0.ack_o), 0);
    tick(1);
    chk("po_e9_ack", int'(bus0.ack_o), 0);
    // Software request accepted at Q=20 on both instances.
    tick(10);
    bus0.req_i = 1'b1; bus1.req_i = 1'b1;
    tick(1);
    bus0.req_i = 1'b0; bus1.req_i = 1'b0;
    chk("sw_q_rst", int'(rst_no0), 3'b000);
    chk("sw_q_busy", int'(bus0.busy_o), 1);
    chk("n1_q_rst", int'(rst_no1), 0);
    tick(1);
    chk("n1_q1_rst", int'(rst_no1), 1);
    chk("n1_q1_ack", int'(bus1.ack_o), 1);
    tick(1);
    chk("n1_q2_ack", int'(bus1.ack_o), 0);
    tick(1);
    chk("sw_q3", int'(rst_no0), 3'b000);
    tick(1);
    chk("sw_q4", int'(rst_no0), 3'b001);
    tick(2);
    chk("sw_q6", int'(rst_no0), 3'b011);
    chk("sw_q6_ack", int'(bus0.ack_o), 0);
    tick(2);
    chk("sw_q8", int'(rst_no0), 3'b111);
    chk("sw_q8_ack", int'(bus0.ack_o), 1);
    tick(1);
    chk("sw_q9_ack", int'(bus0.ack_o), 0);
    // Hardware reset three edges into a software sequence.
    tick(2);
    bus0.req_i = 1'b1;
    tick(1);
    bus0.req_i = 1'b0;
    tick(2);
    rstn0 = 1'b0;
    tick(1);
    chk("abort_rst", int'(rst_no0), 3'b000);
    chk("abort_ack", int'(bus0.ack_o), 0);
    rstn0 = 1'b1;
    tick(4);
    chk("abort_e4", int'(rst_no0), 3'b001);
    tick(4);
    chk("abort_e8", int'(rst_no0), 3'b111);
    chk("abort_e8_ack", int'(bus0.ack_o), 0);
    tick(1);
    chk("abort_e9_ack", int'(bus0.ack_o), 0);
    // Request held high: back-to-back sequences.
    bus0.req_i = 1'b1;
    tick(1);
    chk("held_q", int'(rst_no0), 3'b000);
    tick(8);
    chk("held_q8", int'(rst_no0), 3'b111);
    chk("held_q8_ack", int'(bus0.ack_o), 1);
    tick(1);
    chk("held_q9", int'(rst_no0), 3'b000);
    chk("held_q9_ack", int'(bus0.ack_o), 0);
    chk("held_q9_busy", int'(bus0.busy_o), 1);
    tick(8);
    chk("held_q17_ack", int'(bus0.ack_o), 1);
    bus0.req_i = 1'b0;
    tick(1);
    chk("held_q18_ack", int'(bus0.ack_o), 0);
    chk("held_q18_rst", int'(rst_no0), 3'b111);
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rst_seq_gen.md
# rst_seq_gen

Synthesizable multi-channel reset sequencer, the in-silicon successor to our testbench clock/reset generator. After the synchronous system reset is released, it holds all channel resets low for a programmable number of cycles. It then releases the channels one at a time in ascending index order, separated by a programmable gap. Software can request a full re-sequence through a req/ack handshake. It sits between the top-level reset input and the per-subsystem reset domains, all on one clock.

## Interface
- `NumChannels`, default 4: number of reset outputs; must be ≥ 1.
- `RstClkCycles`, default 16: hold cycles before channel 0 is released; must be ≥ 1.
- `GapClkCycles`, default 4: cycles between the release of channel i−1 and channel i; must be ≥ 1.
- `CntWidth`, default `$clog2(max(RstClkCycles, GapClkCycles) + 1)`: internal counter width; derived, do not override.
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: synchronous, active-low reset, sampled on the `clk_i` rising edge.
- `req_i`  in  1: level re-sequence request; honoured only in IDLE.
- `ack_o`  out  1: one-cycle pulse when a software-requested sequence completes.
- `busy_o`  out  1: high while any channel is held in reset (HOLD or RELEASE).
- `rst_no`  out  NumChannels: active-low channel resets, all driven directly from flops.

## Operation
- States are HOLD, RELEASE and IDLE. Internal registers are `cnt` (CntWidth bits), `idx` (channel index) and `sw` (request-origin flag).
- Reset (`rst_ni`=0 at an edge):
  - state=HOLD, cnt=0, idx=0, sw=0.
  - rst_no all 0, busy_o=1, ack_o=0.
- HOLD:
  - While cnt≠RstClkCycles−1: cnt increments each edge.
  - When cnt=RstClkCycles−1: at the next edge rst_no[0]←1 and cnt←0.
  - If NumChannels=1, next state is IDLE. Otherwise next state is RELEASE with idx←1.
- RELEASE:
  - While cnt≠GapClkCycles−1: cnt increments each edge.
  - When cnt=GapClkCycles−1: at the next edge rst_no[idx]←1 and cnt←0.
  - If idx=NumChannels−1, next state is IDLE. Otherwise idx increments.
- Completion:
  - The edge that releases the last channel also sets busy_o←0.
  - On that same edge, ack_o←sw and sw←0.
  - ack_o clears on the following edge.
- IDLE:
  - All rst_no=1, busy_o=0.
  - If req_i=1 at an edge: all rst_no←0, busy_o←1, sw←1, cnt←0, idx←0, state←HOLD.
- Boundary rules:
  - req_i in HOLD/RELEASE is ignored: no restart, no counter change, no extra ack.
  - A level req_i held high through completion re-triggers on the first IDLE edge. Masters must drop req_i on ack_o.
  - `rst_ni`=0 mid-sequence (hardware or software) aborts immediately to the reset values. sw is cleared and no ack_o is produced.
  - Released channels never re-assert except through `rst_ni` or an accepted req_i.
  - Counter never wraps: it saturates logically at the terminal compare and is cleared at each release.

## Timing
- Number edges from E0, the last edge with `rst_ni`=0.
  - rst_no[0] rises at edge E_R, where R=RstClkCycles.
  - rst_no[i] rises at edge E_(R+i·G), where G=GapClkCycles.
  - busy_o falls at edge E_(R+(N−1)·G).
- Software path: take the request accepted at edge Q.
  - Edge Q drops all rst_no.
  - rst_no[i] rises at edge Q+R+i·G.
  - ack_o is high for exactly the cycle after edge Q+R+(N−1)·G.
- Request latency: one edge from req_i sampled high in IDLE to all rst_no low.
- All outputs are registered, with no combinational input→output paths.

## Test plan
- N=3, R=4, G=2; release rst_ni at E0 -> rst_no[0] rises at E4, [1] at E6, [2] at E8; busy_o falls at E8; ack_o stays 0.
- Same config, IDLE, 1-cycle req_i at edge Q=20 -> rst_no=000 at Q; 001 at 24, 011 at 26, 111 at 28; ack_o=1 only during cycle 28–29.
- req_i pulsed at E5 during the power-on sequence -> timing identical to scenario 1; no ack_o.
- rst_ni asserted at edge Q+3 during a software sequence, released next cycle -> all rst_no=0 and ack_o=0; sequence restarts from E0 timing with no ack at completion.
- N=1, R=1, G=1 -> rst_no[0] rises at E1, busy_o falls at E1; req at Q gives ack_o during cycle Q+1.
- req_i held high continuously -> sequences repeat back-to-back. Each completion gives one ack_o pulse and re-acceptance on the next edge, so rst_no drops one cycle after release.
